// File: rtl/dshot_pwm_output.sv
// rtl/dshot_pwm_output.sv - DShot throttle to 1000..2000 us PWM frame generator with arm/disarm FSM
// Optional feature macro: DSHOT_PWM_FAILSAFE_EN (disarm and flag failsafe when strobes stop arriving).
module dshot_pwm_output #(
    parameter int CLK_HZ     = 16000000,
    parameter int PERIOD_US  = 2500,
    parameter int TIMEOUT_MS = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] speed_in,
    input  logic        speed_valid,
    input  logic        stop_cmd,
    output logic        pwm_out,
    output logic        armed,
    output logic        failsafe,
    output logic [10:0] active_speed
);
    localparam int     HALF_US    = CLK_HZ / 2000000;
    localparam longint PERIOD_CYC = longint'(PERIOD_US) * longint'(CLK_HZ) / 1000000;
    localparam int     CW         = $clog2(PERIOD_CYC);
    localparam logic [CW-1:0] LAST_CNT = CW'(PERIOD_CYC - 1);

    typedef enum logic {DISARMED, ARMED} state_t;

    state_t      state, stateNext;
    logic [CW-1:0] periodCnt;
    logic [10:0] pending, pendingNext, activeNext, clamped;
    logic        frameLive, liveNext, pwmNext, frameStart, stopping, timeoutHit;
    logic [31:0] widthCyc;

`ifdef DSHOT_PWM_FAILSAFE_EN
    localparam longint TIMEOUT_CYC = longint'(TIMEOUT_MS) * longint'(CLK_HZ) / 1000;
    localparam int     TCW         = $clog2(TIMEOUT_CYC);
    localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYC - 1);

    logic [TCW-1:0] timeoutCnt;
    logic           failsafeReg;

    assign timeoutHit = (state == ARMED) && !speed_valid && (timeoutCnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            timeoutCnt  <= '0;
            failsafeReg <= 1'b0;
        end else begin
            timeoutCnt <= (state == ARMED && stateNext == ARMED && !speed_valid)
                          ? timeoutCnt + 1'b1 : '0;
            if (timeoutHit)
                failsafeReg <= 1'b1;
            else if (speed_valid)
                failsafeReg <= 1'b0;
        end
    end

    assign failsafe = failsafeReg;
`else
    assign timeoutHit = 1'b0;
    assign failsafe   = 1'b0;
`endif

    // Width follows the register loaded at frame start; count 0 is always high when live.
    assign widthCyc   = 32'(2000 * HALF_US) + 32'(active_speed) * 32'(HALF_US);
    assign frameStart = (periodCnt == '0);
    assign clamped    = (speed_in > 11'd1999) ? 11'd1999 : speed_in;

    always_comb begin
        stateNext = state;
        case (state)
            DISARMED: if (speed_valid && speed_in == 11'd0) stateNext = ARMED;
            ARMED:    if (stop_cmd || timeoutHit)            stateNext = DISARMED;
            default:  stateNext = DISARMED;
        endcase

        stopping    = (state == ARMED) && (stateNext == DISARMED);
        pendingNext = pending;
        if (stopping)
            pendingNext = 11'd0;
        else if (speed_valid)
            pendingNext = clamped;

        activeNext = active_speed;
        if (stateNext == DISARMED)
            activeNext = 11'd0;
        else if (frameStart)
            activeNext = pendingNext;

        // A frame only carries a pulse if it began with the FSM already armed.
        liveNext = frameLive && (stateNext == ARMED);
        if (frameStart)
            liveNext = (state == ARMED) && (stateNext == ARMED);

        pwmNext = liveNext && (frameStart || (32'(periodCnt) < widthCyc));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= DISARMED;
            periodCnt    <= '0;
            pending      <= 11'd0;
            active_speed <= 11'd0;
            frameLive    <= 1'b0;
            pwm_out      <= 1'b0;
        end else begin
            state        <= stateNext;
            periodCnt    <= (periodCnt == LAST_CNT) ? '0 : periodCnt + 1'b1;
            pending      <= pendingNext;
            active_speed <= activeNext;
            frameLive    <= liveNext;
            pwm_out      <= pwmNext;
        end
    end

    assign armed = (state == ARMED);
endmodule

// File: tb/tb_dshot_pwm_output.sv
// tb/tb_dshot_pwm_output.sv - self-checking bench for dshot_pwm_output (scaled clock, frame-level reference model)
module tb_dshot_pwm_output;
    localparam int CLK_HZ     = 2000000;
    localparam int PERIOD_US  = 2000;
    localparam int TIMEOUT_MS = 5;
    localparam int HALF       = CLK_HZ / 2000000;
    localparam int P          = PERIOD_US * (CLK_HZ / 1000000);
    localparam int TO         = TIMEOUT_MS * (CLK_HZ / 1000);
`ifdef DSHOT_PWM_FAILSAFE_EN
    localparam bit FS = 1'b1;
`else
    localparam bit FS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] speed_in;
    logic        speed_valid;
    logic        stop_cmd;
    logic        pwm_out;
    logic        armed;
    logic        failsafe;
    logic [10:0] active_speed;

    dshot_pwm_output #(.CLK_HZ(CLK_HZ), .PERIOD_US(PERIOD_US), .TIMEOUT_MS(TIMEOUT_MS)) dut (
        .clk(clk), .reset(reset), .speed_in(speed_in), .speed_valid(speed_valid),
        .stop_cmd(stop_cmd), .pwm_out(pwm_out), .armed(armed), .failsafe(failsafe),
        .active_speed(active_speed)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: frame-level view indexed by edge number since reset release.
    int n, mPending, mRun, frameW, frameDis, highCnt, lastPulse;
    bit mArmed, mFail, frameLive;

    typedef struct {
        int speed;
        int expWidth;
    } vec_t;
    vec_t table_v[6];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            if (miscompares <= 30) $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, n);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic modelReset();
        n = 0; mPending = 0; mRun = 0; frameW = 0; frameDis = P; highCnt = 0; lastPulse = 0;
        mArmed = 0; mFail = 0; frameLive = 0;
    endtask

    task automatic resetDut();
        reset = 1'b1; speed_valid = 1'b0; stop_cmd = 1'b0; speed_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pwm", pwm_out, 0);
        check("reset_armed", armed, 0);
        check("reset_failsafe", failsafe, 0);
        check("reset_active", active_speed, 0);
        reset = 1'b0;
        modelReset();
    endtask

    task automatic tick(input bit sv, input int spd, input bit st);
        int pos;
        bit prevArmed, dis, tmo;
        speed_valid = sv; speed_in = 11'(spd); stop_cmd = st;
        @(posedge clk);
        pos = n % P; prevArmed = mArmed; dis = 0; tmo = 0;
        if (mArmed) begin
            if (st) dis = 1;
            else if (FS && !sv && mRun == TO - 1) begin dis = 1; tmo = 1; end
        end else if (sv && spd == 0) mArmed = 1;
        if (dis) mArmed = 0;
        if (dis) mPending = 0;
        else if (sv) mPending = (spd > 1999) ? 1999 : spd;
        mRun = (prevArmed && mArmed && !sv) ? mRun + 1 : 0;
        if (tmo) mFail = 1;
        else if (sv) mFail = 0;
        if (pos == 0) begin
            frameLive = prevArmed && mArmed;
            frameW = HALF * (2000 + mPending);
            frameDis = P;
        end else if (dis && frameDis == P) frameDis = pos;
        #1;
        highCnt += int'(pwm_out);
        check("armed", armed, mArmed);
        check("failsafe", failsafe, mFail);
        if (pos == 0) check("active_speed", active_speed, mArmed ? mPending : 0);
        if (pos == P - 1) begin
            lastPulse = highCnt;
            check("pulse_width", highCnt, frameLive ? imin(frameW, frameDis) : 0);
            highCnt = 0;
        end
        n++;
        speed_valid = 1'b0; stop_cmd = 1'b0;
    endtask

    task automatic runTo(input int target);
        while (n % P != target) tick(0, 0, 0);
    endtask

    initial begin
        int prevW;
        table_v[0] = '{1000, 3000};
        table_v[1] = '{2047, 3999};
        table_v[2] = '{1,    2001};
        table_v[3] = '{1999, 3999};
        table_v[4] = '{0,    2000};
        table_v[5] = '{2000, 3999};

        resetDut();

        // Arm with speed 0 mid-frame: first pulse only in the following frame.
        runTo(100);
        tick(1, 0, 0);
        check("arm_armed", armed, 1);
        runTo(0);
        check("arm_first_frame_pulse", lastPulse, 0);
        tick(0, 0, 0);
        runTo(0);
        check("arm_pulse_2000", lastPulse, 2000);

        // Mid-pulse updates leave the running pulse alone and apply next frame.
        prevW = 2000;
        for (int i = 0; i < 6; i++) begin
            runTo(500);
            tick(1, table_v[i].speed, 0);
            runTo(0);
            check("table_pulse_unchanged", lastPulse, prevW);
            tick(0, 0, 0);
            check("table_active", active_speed, table_v[i].expWidth - 2000);
            prevW = table_v[i].expWidth;
        end
        runTo(0);
        check("table_last_pulse", lastPulse, prevW);

        // Strobe coinciding with frame start applies to that frame.
        tick(1, 700, 0);
        check("framestart_active", active_speed, 700);
        runTo(0);
        check("framestart_pulse", lastPulse, 2700);

        // Stop beats a simultaneous speed strobe; pulse is cut the next cycle.
        runTo(1000);
        tick(1, 500, 1);
        check("stop_armed", armed, 0);
        check("stop_pwm_low", pwm_out, 0);
        check("stop_active", active_speed, 0);
        runTo(0);
        check("stop_truncated", lastPulse, 1000);
        tick(0, 0, 0);
        runTo(0);
        check("stop_no_pulse", lastPulse, 0);

        // Non-zero speed while disarmed does not arm; speed 0 does.
        runTo(200);
        tick(1, 800, 0);
        check("disarmed_stays", armed, 0);
        runTo(300);
        tick(1, 0, 0);
        check("rearm", armed, 1);
        runTo(0);
        check("rearm_frame_empty", lastPulse, 0);
        tick(0, 0, 0);
        runTo(0);
        check("rearm_pulse", lastPulse, 2000);

        // Reset in the middle of a pulse.
        runTo(1500);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_pwm", pwm_out, 0);
        check("midreset_armed", armed, 0);
        resetDut();
        tick(1, 0, 0);
        check("after_reset_arm", armed, 1);

`ifdef DSHOT_PWM_FAILSAFE_EN
        tick(1, 300, 0);
        repeat (TO + 20) tick(0, 0, 0);
        check("fs_failsafe", failsafe, 1);
        check("fs_armed", armed, 0);
        check("fs_pwm", pwm_out, 0);
        tick(1, 0, 0);
        check("fs_cleared", failsafe, 0);
        check("fs_rearmed", armed, 1);
`endif

        // Random traffic against the model.
        for (int k = 0; k < 2 * P; k++) begin
            int r;
            r = int'($urandom_range(0, 2999));
            if (r < 10)
                tick(1, int'($urandom_range(0, 2047)), 0);
            else if (r == 10)
                tick(0, 0, 1);
            else if (r < 14 && !mArmed)
                tick(1, 0, 0);
            else if (r == 14)
                tick(1, int'($urandom_range(0, 2047)), 1);
            else
                tick(0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dshot_pwm_output.md
DSHOT_PWM_OUTPUT -- requirements
Module: dshot_pwm_output

Interface
REQ-001 SHALL have parameter CLK_HZ, default 16000000, the system clock frequency in Hz.
REQ-002 SHALL have parameter PERIOD_US, default 2500, the PWM frame period in microseconds (400 Hz).
REQ-003 SHALL have parameter TIMEOUT_MS, default 100, the failsafe window in milliseconds.
REQ-004 SHALL have port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port speed_in, input, 11 bits: decoded throttle, 0..1999 (DShot value minus 48).
REQ-007 SHALL have port speed_valid, input, 1 bit: one-cycle strobe; CRC-valid, non-command frame present on speed_in.
REQ-008 SHALL have port stop_cmd, input, 1 bit: one-cycle strobe; a valid motor-stop special command was received.
REQ-009 SHALL have port pwm_out, output, 1 bit: the ESC/servo pulse output.
REQ-010 SHALL have port armed, output, 1 bit: high in state ARMED.
REQ-011 SHALL have port failsafe, output, 1 bit: high after a timeout, until the next speed_valid.
REQ-012 SHALL have port active_speed, output, 11 bits: the throttle value driving the current frame.

Function
REQ-013 SHALL derive HALF_US = CLK_HZ/2000000 cycles and PERIOD_CYC = PERIOD_US*CLK_HZ/1000000 cycles.
REQ-014 SHALL run a free-running period counter 0..PERIOD_CYC-1 that wraps to 0; the count-0 cycle is the frame start.
REQ-015 SHALL clamp speed_in values above 1999 to 1999 when latching them into the pending register.
REQ-016 SHALL load the pending register on every speed_valid, with the last strobe winning.
REQ-017 SHALL copy pending to active_speed only at frame start, so an update never changes a pulse already in progress.
REQ-018 SHALL use the value latched in that same cycle if speed_valid coincides with frame start.
REQ-019 SHALL make the pulse width 2000*HALF_US + active_speed*HALF_US cycles (1000.0..1999.5 us) when ARMED.
REQ-020 SHALL drive pwm_out high from count 0 until the count equals the width, then low, as a registered output.
REQ-021 SHALL implement FSM states DISARMED (reset state) and ARMED.
REQ-022 SHALL move DISARMED -> ARMED on speed_valid with speed_in == 0; a non-zero speed while DISARMED updates pending but does not arm.
REQ-023 SHALL move ARMED -> DISARMED on stop_cmd, which takes priority over a simultaneous speed_valid.
REQ-024 SHALL hold pwm_out low for whole frames while DISARMED and force pending and active_speed to 0.
REQ-025 SHALL, on a transition to DISARMED mid-pulse, drive pwm_out low on the next cycle.
REQ-026 SHALL start the first pulse at the next frame start after arming.

Reset
REQ-027 SHALL set on reset: pwm_out=0, armed=0, failsafe=0, active_speed=0, pending=0, period counter=0, timeout counter=0, state DISARMED.
REQ-028 SHALL honour a reset asserted mid-pulse: pwm_out=0 in the next cycle, and counting restarts at 0 after release.

Configuration
REQ-029 SHALL, when macro DSHOT_PWM_FAILSAFE_EN is defined, run a timeout counter that is cleared by speed_valid and counts in ARMED.
REQ-030 SHALL, when that counter reaches TIMEOUT_MS*CLK_HZ/1000 cycles, enter DISARMED and set failsafe=1.
REQ-031 SHALL clear failsafe on the next speed_valid.
REQ-032 SHALL, when DSHOT_PWM_FAILSAFE_EN is undefined, include no timeout logic, tie failsafe to 0, and leave ARMED only via stop_cmd or reset.

Verification
REQ-033 SHALL cover: reset, then speed_valid with speed 0 -> armed=1; next frame pwm_out high for exactly 16000 cycles every 40000 cycles.
REQ-034 SHALL cover: armed, speed 1000 strobed mid-pulse -> current pulse unchanged; next pulse 24000 cycles, active_speed=1000.
REQ-035 SHALL cover: armed, speed_in=2047 -> clamped to 1999; pulse 31992 cycles.
REQ-036 SHALL cover: armed, stop_cmd and speed_valid (500) in the same cycle -> armed=0; pwm_out low next cycle and in all following frames.
REQ-037 SHALL cover: disarmed, speed 800 -> stays disarmed, no pulses; then speed 0 -> arms; next pulse 16000 cycles.
REQ-038 SHALL cover, with DSHOT_PWM_FAILSAFE_EN: armed, no strobes for 1600000 cycles -> failsafe=1, armed=0, pwm_out low; then speed 0 -> failsafe=0, re-armed.
